// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
// Reset manager living in the PLL output clock domain. It synchronises the
// raw PLL lock flag, waits for it to stay high for LOCK_STABLE_CYCLES, then
// releases NUM_RESETS active-high domain resets one after another,
// STAGGER_CYCLES apart, lowest index first. Loss of lock while releasing or
// running re-asserts every reset and bumps a saturating loss counter. A
// software reset request while running replays the staggered release
// without waiting for lock again.
//
// Ports
//   clock_in        PLL output clock, all logic on the rising edge
//   rst_in          asynchronous active-low reset
//   pll_locked_in   raw PLL lock flag, asynchronous to clock_in
//   sw_reset_in     single-cycle software reset request (honoured in RUN only)
//   reset_out       active-high domain resets, bit 0 released first
//   ready_out       high only while in RUN
//   state_out       0 WAIT_LOCK, 1 STABLE, 2 RELEASE, 3 RUN
//   lock_lost_count saturating count of lock losses seen in RELEASE/RUN
module pll_reset_sequencer #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int NUM_RESETS         = 4,
    parameter int STAGGER_CYCLES     = 16,
    parameter int CNT_W              = 8
) (
    input  logic                  clock_in,
    input  logic                  rst_in,
    input  logic                  pll_locked_in,
    input  logic                  sw_reset_in,
    output logic [NUM_RESETS-1:0] reset_out,
    output logic                  ready_out,
    output logic [1:0]            state_out,
    output logic [CNT_W-1:0]      lock_lost_count
);

    // Counter widths are chosen so the terminal values fit without wrapping.
    localparam int RELEASE_LEN = NUM_RESETS * STAGGER_CYCLES;
    localparam int STABLE_W    = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int STAG_W      = $clog2(RELEASE_LEN + 1);

    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [STAG_W-1:0]   STAG_LAST   = STAG_W'(RELEASE_LEN);
    localparam logic [CNT_W-1:0]    CNT_MAX     = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STABLE    = 2'd1,
        ST_RELEASE   = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   lock_s;
    state_t                 state_r;
    logic [STABLE_W-1:0]    stable_r;
    logic [STAG_W-1:0]      stagger_r;
    logic [STAG_W-1:0]      stagger_next_s;
    logic [NUM_RESETS-1:0]  release_hit_s;
    logic [NUM_RESETS-1:0]  reset_r;
    logic                   ready_r;
    logic [CNT_W-1:0]       lost_r;

    // Saturating increment for the lock-loss counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value == CNT_MAX) begin
            result = value;
        end else begin
            result = value + CNT_W'(1);
        end
        return result;
    endfunction

    // Lock flag synchroniser; bit 0 takes the raw input.
    always_ff @(posedge clock_in or negedge rst_in) begin
        if (!rst_in) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], pll_locked_in};
        end
    end

    assign lock_s = sync_r[SYNC_STAGES-1];

    // Which reset bit (if any) drops on the coming edge of the release phase.
    // Bit i drops when the post-edge stagger count reaches (i+1)*STAGGER_CYCLES.
    always_comb begin
        stagger_next_s = stagger_r + STAG_W'(1);
        release_hit_s  = '0;
        for (int i = 0; i < NUM_RESETS; i++) begin
            if (stagger_next_s == STAG_W'((i + 1) * STAGGER_CYCLES)) begin
                release_hit_s[i] = 1'b1;
            end else begin
                release_hit_s[i] = 1'b0;
            end
        end
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clock_in or negedge rst_in) begin
        if (!rst_in) begin
            state_r   <= ST_WAIT_LOCK;
            stable_r  <= '0;
            stagger_r <= '0;
            reset_r   <= '1;
            ready_r   <= 1'b0;
            lost_r    <= '0;
        end else begin
            case (state_r)
                ST_WAIT_LOCK: begin
                    reset_r   <= '1;
                    ready_r   <= 1'b0;
                    stable_r  <= '0;
                    stagger_r <= '0;
                    if (lock_s) begin
                        state_r <= ST_STABLE;
                    end
                end

                ST_STABLE: begin
                    if (!lock_s) begin
                        state_r  <= ST_WAIT_LOCK;
                        stable_r <= '0;
                    end else if (stable_r == STABLE_LAST) begin
                        state_r   <= ST_RELEASE;
                        stable_r  <= '0;
                        stagger_r <= '0;
                    end else begin
                        stable_r <= stable_r + STABLE_W'(1);
                    end
                end

                ST_RELEASE: begin
                    if (!lock_s) begin
                        state_r   <= ST_WAIT_LOCK;
                        reset_r   <= '1;
                        ready_r   <= 1'b0;
                        stagger_r <= '0;
                        lost_r    <= sat_inc(lost_r);
                    end else if (stagger_r == STAG_LAST) begin
                        // Last reset dropped on the previous edge.
                        state_r   <= ST_RUN;
                        ready_r   <= 1'b1;
                        stagger_r <= '0;
                    end else begin
                        stagger_r <= stagger_next_s;
                        reset_r   <= reset_r & ~release_hit_s;
                    end
                end

                ST_RUN: begin
                    // Lock loss takes precedence over a software request.
                    if (!lock_s) begin
                        state_r <= ST_WAIT_LOCK;
                        reset_r <= '1;
                        ready_r <= 1'b0;
                        lost_r  <= sat_inc(lost_r);
                    end else if (sw_reset_in) begin
                        state_r   <= ST_RELEASE;
                        reset_r   <= '1;
                        ready_r   <= 1'b0;
                        stagger_r <= '0;
                    end else begin
                        reset_r <= '0;
                        ready_r <= 1'b1;
                    end
                end

                default: begin
                    state_r   <= ST_WAIT_LOCK;
                    stable_r  <= '0;
                    stagger_r <= '0;
                    reset_r   <= '1;
                    ready_r   <= 1'b0;
                end
            endcase
        end
    end

    assign reset_out       = reset_r;
    assign ready_out       = ready_r;
    assign state_out       = state_r;
    assign lock_lost_count = lost_r;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Testbench for pll_reset_sequencer. Inputs are driven one time unit after
// each falling edge; a behavioural model (phase + edges-since-entry, resets
// derived arithmetically from elapsed time) predicts the outputs after the
// following rising edge and queues them. A monitor on the next falling edge
// pops and compares.
module tb_pll_reset_sequencer;

    localparam int SYNC = 2;
    localparam int LSC  = 8;
    localparam int NR   = 3;
    localparam int STG  = 4;
    localparam int CW   = 2;

    logic          clock_in = 1'b0;
    logic          rst_in;
    logic          pll_locked_in;
    logic          sw_reset_in;
    logic [NR-1:0] reset_out;
    logic          ready_out;
    logic [1:0]    state_out;
    logic [CW-1:0] lock_lost_count;

    pll_reset_sequencer #(
        .SYNC_STAGES       (SYNC),
        .LOCK_STABLE_CYCLES(LSC),
        .NUM_RESETS        (NR),
        .STAGGER_CYCLES    (STG),
        .CNT_W             (CW)
    ) dut (
        .clock_in       (clock_in),
        .rst_in         (rst_in),
        .pll_locked_in  (pll_locked_in),
        .sw_reset_in    (sw_reset_in),
        .reset_out      (reset_out),
        .ready_out      (ready_out),
        .state_out      (state_out),
        .lock_lost_count(lock_lost_count)
    );

    always #5 clock_in = ~clock_in;

    typedef struct packed {
        logic [NR-1:0] rst;
        logic          rdy;
        logic [1:0]    st;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   fails  = 0;

    // Reference model: phase (0 wait, 1 stable, 2 release, 3 run), edges
    // since entering that phase, loss count, and the synchroniser history.
    int m_state;
    int m_e;
    int m_cnt;
    bit m_sync[SYNC];

    function automatic void model_reset();
        m_state = 0;
        m_e     = 0;
        m_cnt   = 0;
        for (int i = 0; i < SYNC; i++) m_sync[i] = 1'b0;
    endfunction

    function automatic void model_lose();
        m_state = 0;
        m_e     = 0;
        if (m_cnt < (1 << CW) - 1) m_cnt++;
    endfunction

    function automatic void model_edge(input bit lock, input bit sw);
        bit ls;
        ls = m_sync[SYNC-1];
        case (m_state)
            0: if (ls) begin m_state = 1; m_e = 0; end
            1: begin
                if (!ls) begin
                    m_state = 0;
                    m_e = 0;
                end else begin
                    m_e++;
                    if (m_e == LSC) begin m_state = 2; m_e = 0; end
                end
            end
            2: begin
                if (!ls) model_lose();
                else begin
                    m_e++;
                    if (m_e == NR * STG + 1) begin m_state = 3; m_e = 0; end
                end
            end
            default: begin
                if (!ls) model_lose();
                else if (sw) begin m_state = 2; m_e = 0; end
            end
        endcase
        for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
        m_sync[0] = lock;
    endfunction

    function automatic exp_t model_out();
        exp_t x;
        for (int i = 0; i < NR; i++) begin
            if (m_state == 3)      x.rst[i] = 1'b0;
            else if (m_state == 2) x.rst[i] = (m_e < (i + 1) * STG);
            else                   x.rst[i] = 1'b1;
        end
        x.rdy = (m_state == 3);
        x.st  = 2'(m_state);
        x.cnt = CW'(m_cnt);
        return x;
    endfunction

    // Drive inputs for the coming rising edge and queue the prediction.
    task automatic drive_now(input bit lock, input bit sw);
        pll_locked_in = lock;
        sw_reset_in   = sw;
        model_edge(lock, sw);
        sb_q.push_back(model_out());
    endtask

    task automatic step(input bit lock, input bit sw);
        @(negedge clock_in);
        #1;
        drive_now(lock, sw);
    endtask

    task automatic steps(input int n, input bit lock);
        for (int i = 0; i < n; i++) step(lock, 1'b0);
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if (reset_out !== {NR{1'b1}} || ready_out !== 1'b0 ||
            state_out !== 2'd0 || lock_lost_count !== '0) begin
            fails++;
            $display("FAIL %s t=%0t got rst=%b rdy=%b st=%0d cnt=%0d, expected rst=%b rdy=0 st=0 cnt=0",
                     name, $time, reset_out, ready_out, state_out, lock_lost_count, {NR{1'b1}});
        end
    endtask

    task automatic release_reset();
        @(negedge clock_in);
        #1;
        rst_in = 1'b1;
        drive_now(1'b0, 1'b0);
    endtask

    // Scoreboard monitor.
    always @(negedge clock_in) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (reset_out !== e.rst || ready_out !== e.rdy ||
                state_out !== e.st || lock_lost_count !== e.cnt) begin
                fails++;
                $display("FAIL outputs t=%0t got rst=%b rdy=%b st=%0d cnt=%0d, expected rst=%b rdy=%b st=%0d cnt=%0d",
                         $time, reset_out, ready_out, state_out, lock_lost_count,
                         e.rst, e.rdy, e.st, e.cnt);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        int lo;
        int guard;

        rst_in        = 1'b0;
        pll_locked_in = 1'b0;
        sw_reset_in   = 1'b0;
        model_reset();
        #12;
        check_reset_values("power_on_reset");

        // Nominal bring-up: lock high from edge 1, RUN at edge 24.
        release_reset();
        steps(30, 1'b1);

        // Lock drop in RUN, relock with a 3-cycle glitch mid-STABLE and a
        // software request during STABLE that must be ignored.
        steps(6, 1'b0);
        steps(6, 1'b1);
        steps(3, 1'b0);
        steps(4, 1'b1);
        step(1'b1, 1'b1);
        steps(30, 1'b1);

        // Software reset in RUN.
        step(1'b1, 1'b1);
        steps(20, 1'b1);

        // Software request coinciding with the synced lock loss in RUN.
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        steps(3, 1'b0);

        // Repeated losses to reach saturation.
        for (int k = 0; k < 4; k++) begin
            steps(30, 1'b1);
            steps(4, 1'b0);
        end

        // Randomised lock bursts with occasional software requests.
        for (int k = 0; k < 40; k++) begin
            hi = int'($urandom_range(5, 40));
            lo = int'($urandom_range(1, 4));
            for (int i = 0; i < hi; i++) step(1'b1, ($urandom_range(0, 15) == 0));
            for (int i = 0; i < lo; i++) step(1'b0, ($urandom_range(0, 7) == 0));
        end

        // Asynchronous reset in the middle of RELEASE.
        guard = 0;
        while (!(m_state == 2 && m_e == 6) && guard < 80) begin
            step(1'b1, 1'b0);
            guard++;
        end
        checks++;
        if (guard >= 80) begin
            fails++;
            $display("FAIL reach_release got state=%0d e=%0d, expected state=2 e=6", m_state, m_e);
        end
        @(negedge clock_in);
        #2;
        rst_in = 1'b0;
        sb_q.delete();
        model_reset();
        #1;
        check_reset_values("async_reset_mid_release");
        @(negedge clock_in);
        #1;
        check_reset_values("reset_held");
        release_reset();
        steps(30, 1'b1);

        @(negedge clock_in);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got %0d pending, expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
